// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO with registered head/valid and an overflow pulse.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [UART_DATA_BITS-1:0]     push_data,
  input  logic                          pop,
  output logic [UART_DATA_BITS-1:0]     head,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q, rd_next;
  logic [CntW-1:0]           count_q, count_d;
  logic [UART_DATA_BITS-1:0] head_q, head_d;
  logic                      valid_q, overflow_q;
  logic                      empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr_q + PtrW'(1);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // The head register must already hold the next entry when the pop edge lands.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (count_q > CntW'(1)) begin
        head_d = mem_q[rd_next];
      end else if (do_push) begin
        head_d = push_data;
      end
    end else if (empty && do_push) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_next;
      end
      count_q    <= count_d;
      head_q     <= head_d;
      valid_q    <= (count_d != '0);
      overflow_q <= push && full && !do_pop;
    end
  end

  assign head     = head_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM and FWFT byte FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_SAMPLES = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [UART_DATA_BITS-1:0]   rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned HALF = CLK_SAMPLES / 2;
  localparam int unsigned CntW = $clog2(CLK_SAMPLES);
  localparam int unsigned IdxW = $clog2(UART_DATA_BITS);

  logic                      sync1_q, rx_s, rx_prev;
  logic [2:0]                warm_q;
  uart_rx_state_t            state_q;
  logic [CntW-1:0]           cnt_q;
  logic [IdxW-1:0]           bit_idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic                      frame_err_q;
  logic                      start_edge, bit_end, push;

  // warm_q blocks the fake falling edge the reset values would show when rx is held low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      warm_q  <= '0;
    end else begin
      sync1_q <= rx;
      rx_s    <= sync1_q;
      rx_prev <= rx_s;
      warm_q  <= {warm_q[1:0], 1'b1};
    end
  end

  assign start_edge = warm_q[2] && rx_prev && !rx_s;
  assign bit_end    = (cnt_q == CntW'(CLK_SAMPLES - 1));
  assign push       = (state_q == STOP) && bit_end && rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == CntW'(HALF - 1)) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg_q[bit_idx_q] <= rx_s;
            cnt_q              <= '0;
            bit_idx_q          <= bit_idx_q + IdxW'(1);
            if (bit_idx_q == IdxW'(UART_DATA_BITS - 1)) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            frame_err_q <= !rx_s;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;

  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg_q),
    .pop       (rx_ready),
    .head      (rx_data),
    .valid     (rx_valid),
    .count     (fifo_count),
    .overflow  (overflow)
  );

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Synthesizable UART receiver for the DUT side of the netcat UART link. It consumes the serial stream that the simulation UART transactor drives: 8N1, LSB first, idle high, CLK_SAMPLES clocks per bit. It deserializes each frame, checks the stop bit and buffers bytes in a small FIFO. The FIFO is read through a valid/ready interface.

Parameters:
CLK_SAMPLES, 4, clock cycles per UART bit; must be even and >= 4; must match the transactor setting.
FIFO_DEPTH, 8, number of byte entries; power of two, >= 2.

Ports:
clk  input  1  single clock for all logic
rst_n  input  1  reset; asynchronous assert, active-low
rx  input  1  serial line from transactor tx; asynchronous to clk; idle 1
rx_data  output  8  FIFO head byte; valid only while rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts head; a pop occurs when rx_valid && rx_ready
frame_err  output  1  1-cycle pulse when a stop bit is sampled as 0
overflow  output  1  1-cycle pulse when a good byte is dropped because the FIFO is full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset is asynchronous and active-low on rst_n; all flops use it.
- Values held in reset:
  - synchronizer flops = 1
  - rx_prev = 1
  - FSM = IDLE; cnt = 0; bit_idx = 0
  - FIFO empty; rx_valid = 0; fifo_count = 0; rx_data = 0
  - frame_err = 0; overflow = 0
- Input path: rx passes through a 2-flop synchronizer to give rx_s. rx_prev is rx_s delayed by one cycle.
- Start detection: rx_prev=1 && rx_s=0.
- Constant HALF = CLK_SAMPLES/2.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on start detection go to START with cnt<=0.
  - START: cnt increments each cycle. At cnt==HALF-1 (mid start bit):
    - rx_s=1: false start, go to IDLE.
    - rx_s=0: go to DATA with cnt<=0 and bit_idx<=0.
  - DATA: at cnt==CLK_SAMPLES-1, shift rx_s into shreg[bit_idx] (LSB first), cnt<=0, bit_idx++. After bit_idx 7 is sampled, go to STOP.
  - STOP: at cnt==CLK_SAMPLES-1, sample rx_s.
    - rx_s=1: push shreg into the FIFO.
    - rx_s=0: frame_err pulses the next cycle; the byte is discarded.
    - In both cases go to IDLE.
- Timing guarantees:
  - Every sample lands mid-bit.
  - The return to IDLE happens mid stop bit, so back-to-back frames with no idle gap are received.
- Break handling: after a framing error with rx held low, no frame starts until rx returns to 1 and falls again. The same applies after reset is released with rx low.
- FIFO is first-word fall-through:
  - rx_data and rx_valid are registered outputs.
  - rx_valid rises the cycle after the STOP sample cycle of a good frame.
  - Pipeline latency from the start edge on rx to rx_valid ≈ 2 + HALF + 9*CLK_SAMPLES + 1 cycles.
- FIFO boundary cases:
  - Push while full with no pop: the byte is dropped, overflow pulses 1 cycle, contents are unchanged.
  - Push and pop in the same cycle while full: both succeed, no overflow, count unchanged.
  - Push and pop in the same cycle while empty: the push happens; no pop occurs.
  - rx_ready while empty: ignored.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty come from fifo_count, never from pointer compare alone.
- frame_err and overflow never pulse in the same cycle: one stop sample produces at most one event.
- Reset asserted mid-frame: the partial byte is lost and nothing is pushed. Reception resumes on the next valid start edge.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] uart_rx_state_t {IDLE, START, DATA, STOP}
  - localparam UART_DATA_BITS = 8
- Sub-module uart_byte_fifo: parameterized FWFT FIFO (FIFO_DEPTH), with ports push/push_data/pop/head/valid/count/overflow.
- uart_rx holds the synchronizer, the FSM and the shift register.

Test Plan:
1. CLK_SAMPLES=4, drive 0x55 as a frame, rx_ready=1 -> exactly one rx_valid beat with rx_data=0x55; frame_err=0.
2. Frames 0xA3 and 0x0F back-to-back with no idle gap, rx_ready=0 -> fifo_count=2. Then assert rx_ready -> pops in order 0xA3, 0x0F; rx_valid=0 after.
3. Frame 0xC1 with stop bit forced to 0 -> one frame_err pulse, fifo_count stays 0. The following normal frame 0x42 is received after rx goes high and then low.
4. Single-cycle low glitch on idle rx -> FSM returns to IDLE from START; no frame_err; fifo_count=0.
5. FIFO_DEPTH=8, rx_ready=0, send 0x00..0x08 (9 frames) -> one overflow pulse on the 9th; pops return 0x00..0x07. Repeat with rx_ready pulsed in the cycle of the 9th push -> no overflow.
6. Assert rst_n=0 after 3 data bits of 0xFF, release, then send 0x7E -> only 0x7E is output. Also run a loopback with the transactor (CLK_SAMPLES=4) sending the string "hi\n" -> bytes 0x68, 0x69, 0x0A.
